// File: rtl/and_cascade_scheduler_pkg.sv
// Shared types and sizing helpers for the AND-cascade scheduler.
// State codes are plain constants so legacy code can compare against them directly.
package and_cascade_scheduler_pkg;

    typedef logic [1:0] schedState_t;

    localparam schedState_t IDLE    = 2'd0;
    localparam schedState_t DRIVE   = 2'd1;
    localparam schedState_t RESPOND = 2'd2;

    // Grant index width; a 2-client build still needs a 1-bit index.
    function automatic int grantWidth(input int requesters);
        return (requesters > 1) ? $clog2(requesters) : 1;
    endfunction

    // Settle counter must be able to hold SETTLE_CYCLES itself.
    function automatic int cntWidth(input int settleCycles);
        return (settleCycles > 1) ? $clog2(settleCycles + 1) : 1;
    endfunction

endpackage

// File: rtl/and_cascade_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module and_cascade_scheduler_rr_arbiter
    import and_cascade_scheduler_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int GRANT_W    = 2
) (
    input  logic [REQUESTERS-1:0] req,
    input  logic [GRANT_W-1:0]    ptr,
    output logic [REQUESTERS-1:0] grant,
    output logic [GRANT_W-1:0]    grantIdx,
    output logic                  anyGrant
);

    always_comb begin
        int                 idx;
        logic [GRANT_W-1:0] idxSel;
        idx      = 0;
        idxSel   = '0;
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        for (int k = 0; k < REQUESTERS; k++) begin
            idx    = (int'(ptr) + k) % REQUESTERS;
            idxSel = GRANT_W'(idx);
            if (!anyGrant && req[idxSel]) begin
                grant[idxSel] = 1'b1;
                grantIdx      = idxSel;
                anyGrant      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/and_cascade_scheduler.sv
// Time-shares one combinational AND cascade between several clients:
// grant, drive the operand, wait the settle time, sample, hand the bit back.
module and_cascade_scheduler
    import and_cascade_scheduler_pkg::*;
#(
    parameter int  LENGTH        = 8,
    parameter int  REQUESTERS    = 4,
    parameter int  SETTLE_CYCLES = 1,
    localparam int GRANT_W       = grantWidth(REQUESTERS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [REQUESTERS-1:0]        req_valid,
    input  logic [REQUESTERS*LENGTH-1:0] req_data,
    output logic [REQUESTERS-1:0]        req_ready,
    output logic [REQUESTERS-1:0]        rsp_valid,
    output logic                         rsp_result,
    input  logic [REQUESTERS-1:0]        rsp_ready,
    output logic [LENGTH-1:0]            dp_in,
    input  logic                         dp_out,
    output logic [GRANT_W-1:0]           grant_id,
    output logic                         busy
);

    localparam int                 CNT_W    = cntWidth(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(1);
    localparam logic [GRANT_W-1:0] LAST_ID  = GRANT_W'(REQUESTERS - 1);

    schedState_t               state;
    logic [GRANT_W-1:0]        rrPtr;
    logic [CNT_W-1:0]          cnt;
    logic                      result;
    logic [REQUESTERS-1:0]     winGrant;
    logic [GRANT_W-1:0]        winIdx;
    logic                      winAny;

    and_cascade_scheduler_rr_arbiter #(
        .REQUESTERS (REQUESTERS),
        .GRANT_W    (GRANT_W)
    ) arbiter (
        .req      (req_valid),
        .ptr      (rrPtr),
        .grant    (winGrant),
        .grantIdx (winIdx),
        .anyGrant (winAny)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rrPtr    <= '0;
            cnt      <= '0;
            dp_in    <= '0;
            result   <= 1'b0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (winAny) begin
                        dp_in    <= req_data[int'(winIdx)*LENGTH +: LENGTH];
                        grant_id <= winIdx;
                        rrPtr    <= (winIdx == LAST_ID) ? '0 : winIdx + 1'b1;
                        cnt      <= CNT_LOAD;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    // dp_in is frozen here; only the final settle cycle's dp_out counts.
                    if (cnt == CNT_LAST) begin
                        result <= dp_out;
                        state  <= RESPOND;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESPOND: begin
                    if (rsp_ready[grant_id]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESPOND) begin
            rsp_valid[grant_id] = 1'b1;
        end
    end

    assign req_ready  = (state == IDLE) ? winGrant : '0;
    assign rsp_result = (state == RESPOND) && result;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_and_cascade_scheduler.sv
// Bench for and_cascade_scheduler: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations, plus a SETTLE_CYCLES=3 instance.
module tb_and_cascade_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  reqValid = '0;
    logic [31:0] reqData = '0;
    logic [3:0]  reqReady;
    logic [3:0]  rspValid;
    logic        rspResult;
    logic [3:0]  rspReady = 4'hF;
    logic [7:0]  dpIn;
    logic        dpOut;
    logic [1:0]  grantId;
    logic        busy;

    logic [3:0]  req3Valid = '0;
    logic [31:0] req3Data = '0;
    logic [3:0]  req3Ready;
    logic [3:0]  rsp3Valid;
    logic        rsp3Result;
    logic [3:0]  rsp3Ready = 4'hF;
    logic [7:0]  dp3In;
    logic        dp3Out = 1'b0;
    logic [1:0]  grant3Id;
    logic        busy3;

    int compared = 0;
    int mismatched = 0;
    int cycleNo = 0;
    bit compareEn = 0;

    always #5 clock = ~clock;

    // 8-input AND cascade behavioural model
    assign dpOut = &dpIn;

    and_cascade_scheduler #(.LENGTH(8), .REQUESTERS(4), .SETTLE_CYCLES(1)) dut (
        .clock(clock), .reset(reset), .req_valid(reqValid), .req_data(reqData),
        .req_ready(reqReady), .rsp_valid(rspValid), .rsp_result(rspResult),
        .rsp_ready(rspReady), .dp_in(dpIn), .dp_out(dpOut), .grant_id(grantId), .busy(busy)
    );

    and_cascade_scheduler #(.LENGTH(8), .REQUESTERS(4), .SETTLE_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset), .req_valid(req3Valid), .req_data(req3Data),
        .req_ready(req3Ready), .rsp_valid(rsp3Valid), .rsp_result(rsp3Result),
        .rsp_ready(rsp3Ready), .dp_in(dp3In), .dp_out(dp3Out), .grant_id(grant3Id), .busy(busy3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", name, act, exp, cycleNo);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Reference model: an in-flight transaction is described by its client, operand
    // and the number of cycles elapsed since it was accepted.
    bit         mHave = 0;
    int         mPtr = 0, mClient = 0, mAge = 0, mLastGid = 0, win = -1;
    logic [7:0] mData = '0, mLastDp = '0;
    logic [3:0] eReqReady, eRspValid;
    logic       eRes, eBusy;
    int         gLog[$], gCyc[$], rLog[$];

    always @(negedge clock) begin
        if (compareEn) begin
            win = -1;
            eReqReady = '0;
            eRspValid = '0;
            eRes = 1'b0;
            eBusy = mHave;
            if (!mHave) begin
                for (int k = 0; k < 4; k++)
                    if (win < 0 && reqValid[(mPtr + k) % 4]) win = (mPtr + k) % 4;
                if (win >= 0) eReqReady = 4'b0001 << win;
            end else if (mAge > 1) begin
                eRspValid = 4'b0001 << mClient;
                eRes = &mData;
            end
            check("req_ready", 32'(reqReady), 32'(eReqReady));
            check("rsp_valid", 32'(rspValid), 32'(eRspValid));
            check("rsp_result", 32'(rspResult), 32'(eRes));
            check("busy", 32'(busy), 32'(eBusy));
            check("grant_id", 32'(grantId), 32'(mLastGid));
            check("dp_in", 32'(dpIn), 32'(mLastDp));

            if (!reset && reqReady != 0)
                for (int k = 0; k < 4; k++)
                    if (reqReady[k]) begin gLog.push_back(k); gCyc.push_back(cycleNo); end
            if (!reset && (rspValid & rspReady) != 0) rLog.push_back(int'(rspResult));

            if (reset) begin
                mHave = 0; mPtr = 0; mLastDp = '0; mLastGid = 0;
            end else if (!mHave) begin
                if (win >= 0) begin
                    mHave = 1; mClient = win; mData = reqData[win*8 +: 8]; mAge = 1;
                    mPtr = (win + 1) % 4; mLastDp = mData; mLastGid = win;
                end
            end else if (mAge <= 1) begin
                mAge++;
            end else if (rspReady[mClient]) begin
                mHave = 0;
            end
        end
        cycleNo++;
    end

    int expOrder[5] = '{0, 1, 2, 3, 0};
    int expRes[4] = '{1, 0, 1, 0};

    initial begin
        repeat (2) @(posedge clock);
        #1;
        compareEn = 1;
        cyc();
        reset = 0;

        // Client 0 sends FF
        cyc(); reqValid = 4'b0001; reqData = 32'h0000_00FF;
        @(negedge clock); check("s1_req_ready", 32'(reqReady), 32'h1);
        cyc(); reqValid = '0;
        @(negedge clock); check("s1_dp_in", 32'(dpIn), 32'hFF);
        @(negedge clock); check("s1_rsp_valid", 32'(rspValid), 32'h1);
        check("s1_rsp_result", 32'(rspResult), 32'h1);
        @(negedge clock); check("s1_busy_low", 32'(busy), 32'h0);

        // Client 2 sends FE
        cyc(); reqValid = 4'b0100; reqData = 32'h00FE_0000;
        @(negedge clock); check("s2_req_ready", 32'(reqReady), 32'h4);
        cyc(); reqValid = '0;
        @(negedge clock);
        @(negedge clock); check("s2_rsp_valid", 32'(rspValid), 32'h4);
        check("s2_rsp_result", 32'(rspResult), 32'h0);
        check("s2_grant_id", 32'(grantId), 32'h2);

        // All four request continuously from reset
        cyc(); reset = 1; reqValid = 4'hF; reqData = 32'h00FF_7FFF; rspReady = 4'hF;
        cyc(); reset = 0; gLog.delete(); gCyc.delete(); rLog.delete();
        repeat (16) cyc();
        reqValid = '0;
        repeat (4) cyc();
        for (int i = 0; i < 5; i++)
            check("s3_grant_order", (i < gLog.size()) ? gLog[i] : -1, expOrder[i]);
        for (int i = 0; i < 4; i++)
            check("s3_grant_spacing", (i + 1 < gCyc.size()) ? gCyc[i+1] - gCyc[i] : -1, 3);
        for (int i = 0; i < 4; i++)
            check("s3_result", (i < rLog.size()) ? rLog[i] : -1, expRes[i]);

        // Client 1 held in RESPOND while client 3 waits
        cyc(); reset = 1;
        cyc(); reset = 0; reqValid = 4'b0010; reqData = 32'h0000_FF00; rspReady = 4'b1101;
        @(negedge clock); check("s4_req_ready", 32'(reqReady), 32'h2);
        cyc(); reqValid = 4'b1000;
        @(negedge clock); check("s4_drive_no_ready", 32'(reqReady), 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clock);
            check("s4_hold_rsp_valid", 32'(rspValid), 32'h2);
            check("s4_hold_result", 32'(rspResult), 32'h1);
            check("s4_hold_req_ready", 32'(reqReady), 32'h0);
        end
        cyc(); rspReady = 4'hF;
        @(negedge clock); check("s4_last_rsp", 32'(rspValid), 32'h2);
        cyc();
        @(negedge clock); check("s4_client3_ready", 32'(reqReady), 32'h8);
        cyc(); reqValid = '0;
        @(negedge clock); check("s4_client3_grant", 32'(grantId), 32'h3);
        repeat (4) cyc();

        // Reset during DRIVE drops the transaction
        cyc(); reqValid = 4'b0100; reqData = 32'h00FF_0000;
        @(negedge clock); check("s5_req_ready", 32'(reqReady), 32'h4);
        cyc(); reqValid = '0; reset = 1;
        @(negedge clock); check("s5_in_drive", 32'(busy), 32'h1);
        cyc(); reset = 0;
        @(negedge clock);
        check("s5_rst_outputs", {reqReady, rspValid, 3'b0, rspResult, 3'b0, busy, 6'b0, grantId, dpIn}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            @(negedge clock); check("s5_no_rsp", 32'(rspValid), 32'h0);
        end
        cyc(); reqValid = 4'b1001; reqData = 32'hFF00_00FF;
        @(negedge clock); check("s5_ptr_reset", 32'(reqReady), 32'h1);
        cyc(); reqValid = '0;
        repeat (4) cyc();

        // Randomized traffic, model-checked every cycle
        for (int i = 0; i < 1500; i++) begin
            cyc();
            reset = ($urandom_range(99) == 0);
            reqValid = 4'($urandom);
            for (int c = 0; c < 4; c++)
                reqData[c*8 +: 8] = ($urandom_range(2) == 0) ? 8'hFF : 8'($urandom);
            rspReady = 4'($urandom);
        end
        cyc(); reset = 0; reqValid = '0; rspReady = 4'hF;
        repeat (4) cyc();

        // SETTLE_CYCLES=3 instance: only the final settle cycle's dp_out matters
        cyc(); req3Valid = 4'b1000; req3Data = 32'hFF00_0000; rsp3Ready = 4'hF; dp3Out = 0;
        @(negedge clock); check("s6_req_ready", 32'(req3Ready), 32'h8);
        cyc(); req3Valid = '0; dp3Out = 0;
        @(negedge clock); check("s6_dp_in", 32'(dp3In), 32'hFF);
        check("s6_t1_rsp", 32'(rsp3Valid), 32'h0);
        cyc(); dp3Out = 0;
        @(negedge clock); check("s6_t2_busy", 32'(busy3), 32'h1);
        check("s6_t2_rsp", 32'(rsp3Valid), 32'h0);
        cyc(); dp3Out = 1;
        @(negedge clock); check("s6_t3_rsp", 32'(rsp3Valid), 32'h0);
        cyc(); dp3Out = 0;
        @(negedge clock); check("s6_rsp_valid", 32'(rsp3Valid), 32'h8);
        check("s6_rsp_result", 32'(rsp3Result), 32'h1);
        check("s6_grant_id", 32'(grant3Id), 32'h3);
        cyc();
        @(negedge clock); check("s6_busy_low", 32'(busy3), 32'h0);
        check("s6_result_low", 32'(rsp3Result), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/and_cascade_scheduler.md
Name: and_cascade_scheduler

Overview:
- Shares one combinational AND-cascade datapath (LENGTH-bit vector in, 1-bit reduction out) between REQUESTERS clients.
- Round-robin arbitration. Registers the winner's operand onto the datapath input and waits a fixed settle time.
- Captures the 1-bit result and returns it to the winner over a valid/ready handshake.
- Sits between the stimulus sources (switch/counter generators) and the AND-cascade instance.

Parameters:
- LENGTH, 8, operand width driven into the cascade.
- REQUESTERS, 4, number of clients; legal range 2..16.
- SETTLE_CYCLES, 1, cycles dp_in is held before dp_out is sampled; legal range ≥1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  REQUESTERS  per-client request.
- req_data  in  REQUESTERS*LENGTH  operands; client i occupies bits [i*LENGTH +: LENGTH].
- req_ready  out  REQUESTERS  one-hot acceptance.
- rsp_valid  out  REQUESTERS  one-hot response valid.
- rsp_result  out  1  AND result for the client whose rsp_valid is set.
- rsp_ready  in  REQUESTERS  per-client response acceptance.
- dp_in  out  LENGTH  registered operand to the cascade.
- dp_out  in  1  cascade output.
- grant_id  out  max(1,clog2(REQUESTERS))  index of current or last grant.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, dp_in=0, result=0, grant_id=0, req_ready=0, rsp_valid=0, rsp_result=0, busy=0.
- Reset overrides everything in the same edge. A transaction in flight is dropped with no response.
- FSM states: IDLE, DRIVE, RESPOND.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo REQUESTERS.
  - req_ready[winner]=1 combinationally this cycle only; all other req_ready bits are 0.
  - On handshake, at the next edge: dp_in ← req_data[winner], grant_id ← winner, rr_ptr ← (winner+1) mod REQUESTERS, cnt ← SETTLE_CYCLES, state → DRIVE.
  - No req_valid: stay in IDLE; dp_in holds its last value.
- DRIVE:
  - cnt decrements each cycle.
  - In the cycle with cnt==1: result ← dp_out at the edge, state → RESPOND.
  - dp_in is stable for the whole DRIVE period.
- RESPOND:
  - rsp_valid[grant_id]=1, rsp_result=result; all other rsp_valid bits are 0.
  - Held, with result stable, until rsp_ready[grant_id]=1. Then state → IDLE at the next edge.
  - rsp_ready bits of other clients are ignored.
- Latency (accept edge = T):
  - DRIVE occupies cycles T+1 .. T+SETTLE_CYCLES.
  - rsp_valid rises in cycle T+SETTLE_CYCLES+1.
  - Minimum spacing between two grants is SETTLE_CYCLES+2 cycles.
- req_ready is 0 in DRIVE and RESPOND. Requests are never queued.
- A client may drop req_valid before it is accepted without side effects.
- Simultaneous requests: exactly one grant. The pointer guarantees each continuously-requesting client is served within REQUESTERS grants.
- Pointer wrap: winner=REQUESTERS-1 gives rr_ptr=0.
- The winner may re-request immediately after its response. It wins again only if no other client is requesting.
- rsp_result is 0 whenever no rsp_valid bit is set.

Decomposition:
- Shared package:
  - State enum {IDLE, DRIVE, RESPOND}.
  - Constant GRANT_W = max(1, clog2(REQUESTERS)).
  - Counter width from SETTLE_CYCLES.
- One natural sub-module: rr_arbiter (combinational). Inputs: req vector, pointer. Outputs: one-hot grant, grant index, any-grant flag.
- FSM, counter and datapath registers stay in the top.

Test Plan:
- Bench configuration: LENGTH=8, REQUESTERS=4, SETTLE_CYCLES=1, 8-input AND behavioural model on dp_out; the last scenario overrides SETTLE_CYCLES.
- Client 0 sends 8'hFF, rsp_ready=1 → req_ready[0] at T, dp_in=8'hFF at T+1, rsp_valid=4'b0001 with rsp_result=1 at T+2, busy low at T+3.
- Client 2 sends 8'hFE → rsp_valid=4'b0100, rsp_result=0, grant_id=2.
- All four clients request continuously from reset, data 8'hFF/8'h7F/8'hFF/8'h00 → grant order 0,1,2,3,0; results 1,0,1,0; grants spaced 3 cycles apart.
- Client 1 granted, rsp_ready[1] held 0 for 5 cycles while client 3 requests → rsp_valid[1] and rsp_result stay stable, req_ready=0. Client 3 is granted the cycle after IDLE is re-entered.
- Reset pulsed during DRIVE → next cycle all outputs 0, state IDLE, rr_ptr=0, no rsp_valid ever asserts for the dropped request.
- SETTLE_CYCLES=3, client 3 sends 8'hFF → rsp_valid[3] at T+4, and dp_out changes in the T+1..T+2 window do not affect the result.
